// File: rtl/gray_sync_rx.sv
// gray_sync_rx: receive side of a Gray-coded count crossing into the clk domain.
// The async Gray input passes through a SYNC_STAGES-deep flop chain. Each new
// synchronized value is converted to binary and reported with a one-cycle
// bin_valid pulse. The pulse carries the modulo step (delta) since the
// previous accepted value.
// Optional multi-bit-change checker: define GRAY_SYNC_ERR_CHK_EN to build it.
// Without it, err and err_cnt are tied low and clr_err is ignored.
module gray_sync_rx #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gray_in,
  input  logic         clr_err,
  output logic [N-1:0] bin_out,
  output logic         bin_valid,
  output logic [N-1:0] delta,
  output logic         err,
  output logic [7:0]   err_cnt
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] g_sync;
  logic [N-1:0] g_prev;
  logic [N-1:0] bin_new;
  logic         chg;

  // MSB-down prefix XOR: b[N-1] = g[N-1], b[i] = b[i+1] ^ g[i]
  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain; nothing sits between stages so metastability can settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_sync  = sync_q[SYNC_STAGES-1];
  assign chg     = (g_sync != g_prev);
  assign bin_new = g2b(g_sync);

  // Previous synchronized sample for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev <= '0;
    end else begin
      g_prev <= g_sync;
    end
  end

  // Data update: new binary value and the modulo step, flagged for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out   <= '0;
      delta     <= '0;
      bin_valid <= 1'b0;
    end else if (chg) begin
      bin_out   <= bin_new;
      delta     <= bin_new - bin_out;
      bin_valid <= 1'b1;
    end else begin
      bin_valid <= 1'b0;
    end
  end

`ifdef GRAY_SYNC_ERR_CHK_EN
  logic [N-1:0] g_diff;
  logic         multi_bit;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  // No change means g_diff is zero, so this only fires on a chg edge.
  assign g_diff    = g_sync ^ g_prev;
  assign multi_bit = ((g_diff & (g_diff - N'(1))) != '0);

  // Sticky error flag and saturating counter; a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (multi_bit) begin
      err <= 1'b1;
      if (clr_err) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (clr_err) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end
  end
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign err            = 1'b0;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_gray_sync_rx.sv
// Directed bench for gray_sync_rx (N=4, SYNC_STAGES=2, so latency is 3 edges).
// Expected err/err_cnt values follow GRAY_SYNC_ERR_CHK_EN.
module tb_gray_sync_rx;

`ifdef GRAY_SYNC_ERR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic [3:0] delta;
  logic       err;
  logic [7:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  gray_sync_rx #(.N(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .delta     (delta),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // count bin_valid pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (bin_valid === 1'b1) pulse_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // apply a Gray value just after an edge and check the update 3 edges later
  task automatic step(input string tag, input logic [3:0] g,
                      input logic [3:0] eb, input logic [3:0] ed);
    gray_in = g;
    tick();
    tick();
    check_val({tag, "_early"}, {31'd0, bin_valid}, 32'd0);
    tick();
    check_val({tag, "_valid"}, {31'd0, bin_valid}, 32'd1);
    check_val({tag, "_bin"},   {28'd0, bin_out},   {28'd0, eb});
    check_val({tag, "_delta"}, {28'd0, delta},     {28'd0, ed});
  endtask

  logic [3:0] seq_g [16];
  logic [3:0] seq_b [16];
  int pulses_before;

  initial begin
    seq_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
              4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    seq_b = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
              4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};

    rst_n   = 1'b0;
    gray_in = 4'b0000;
    clr_err = 1'b0;
    #12;
    rst_n = 1'b1;

    // idle after reset: everything stays zero
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val($sformatf("idle%0d", i),
                {15'd0, bin_out, delta, bin_valid, err, err_cnt}, 32'd0);
    end

    // first step with single-cycle pulse check, then the rest of the sequence
    step("s1", seq_g[0], seq_b[0], 4'd1);
    tick();
    check_val("s1_one_cycle", {31'd0, bin_valid}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      step($sformatf("seq%0d", i), seq_g[i], seq_b[i], 4'd1);
    end
    tick();
    check_val("wrap_pulses", pulse_cnt, 32'd16);
    check_val("wrap_err",    {31'd0, err}, 32'd0);
    check_val("wrap_errcnt", {24'd0, err_cnt}, 32'd0);

    // 0000 -> 0011 flips two bits
    step("jump1", 4'b0011, 4'd2, 4'd2);
    check_val("jump1_err",    {31'd0, err}, {31'd0, CHK});
    check_val("jump1_errcnt", {24'd0, err_cnt}, CHK ? 32'd1 : 32'd0);

    // 0011 -> 0101 with clr_err on the update edge: set wins, count restarts at 1
    gray_in = 4'b0101;
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_val("jump2_bin",    {28'd0, bin_out}, 32'd6);
    check_val("jump2_delta",  {28'd0, delta},   32'd4);
    check_val("jump2_err",    {31'd0, err}, {31'd0, CHK});
    check_val("jump2_errcnt", {24'd0, err_cnt}, CHK ? 32'd1 : 32'd0);

    // plain clear
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_val("clr_err",    {31'd0, err}, 32'd0);
    check_val("clr_errcnt", {24'd0, err_cnt}, 32'd0);

    // 300 two-bit jumps, one per cycle, ending on 0000 from 0011
    pulses_before = pulse_cnt;
    for (int k = 1; k <= 300; k++) begin
      gray_in = (k % 2 == 1) ? 4'b0011 : 4'b0000;
      tick();
    end
    repeat (4) tick();
    check_val("sat_pulses", pulse_cnt - pulses_before, 32'd300);
    check_val("sat_errcnt", {24'd0, err_cnt}, CHK ? 32'd255 : 32'd0);
    check_val("sat_err",    {31'd0, err}, {31'd0, CHK});
    check_val("sat_bin",    {28'd0, bin_out}, 32'd0);
    check_val("sat_delta",  {28'd0, delta},   32'd14);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_val("sat_clr_err",    {31'd0, err}, 32'd0);
    check_val("sat_clr_errcnt", {24'd0, err_cnt}, 32'd0);

    // mid-stream async reset with bin_out = 9
    step("pre_rst", 4'b1101, 4'd9, 4'd9);
    gray_in = 4'b0110;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst",
              {15'd0, bin_out, delta, bin_valid, err, err_cnt}, 32'd0);
    tick();
    tick();
    check_val("in_rst",
              {15'd0, bin_out, delta, bin_valid, err, err_cnt}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check_val("post_rst_early", {31'd0, bin_valid}, 32'd0);
    tick();
    check_val("post_rst_valid", {31'd0, bin_valid}, 32'd1);
    check_val("post_rst_bin",   {28'd0, bin_out},   32'd4);
    check_val("post_rst_delta", {28'd0, delta},     32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_sync_rx.md
# gray_sync_rx

Receive-side companion to the free-running Gray counter: takes an N-bit Gray count that is asynchronous to `clk`, synchronizes it through a flop chain, converts it to binary, and reports each change as a one-cycle `bin_valid` pulse with the modulo step size since the previous update. Sits in the consuming clock domain, e.g. a FIFO read/write pointer crossing or a remote event counter. It can also optionally check that each observed change flips exactly one bit.

## Interface

- `N`, 4, Gray/binary width (≥2)
- `SYNC_STAGES`, 2, synchronizer depth (≥2)

- `clk`  in  1  destination-domain clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `gray_in`  in  N  Gray count from the foreign domain; asynchronous to `clk`
- `clr_err`  in  1  synchronous clear of `err`/`err_cnt`
- `bin_out`  out  N  binary value of the last accepted Gray sample
- `bin_valid`  out  1  one-cycle pulse: `bin_out`/`delta` updated this cycle
- `delta`  out  N  (new − previous `bin_out`) mod 2^N, valid with `bin_valid`
- `err`  out  1  sticky: a change with Hamming distance >1 was seen
- `err_cnt`  out  8  saturating count of such changes

## Operation

- Synchronizer: `gray_in` → `SYNC_STAGES` flops; the last stage is `g_sync`. No logic between the synchronizer flops.
- `g_prev` is a register that copies `g_sync` every cycle.
- `chg = (g_sync != g_prev)`. The binary value is `b[N-1] = g[N-1]` and `b[i] = b[i+1] ^ g[i]` (MSB-down prefix XOR).
- On a clock edge with `chg=1`:
  - `bin_out <= g2b(g_sync)`
  - `delta <= g2b(g_sync) − bin_out`, truncated to N bits
  - `bin_valid <= 1`
- On a clock edge with `chg=0`: `bin_valid <= 0`, and `bin_out`/`delta` hold.
- Wrap-around is natural: binary 2^N−1 → 0 gives `delta=1`.
- Error check (runs on a `chg` edge): if popcount(`g_sync ^ g_prev`) > 1:
  - `err <= 1`
  - `err_cnt <= err_cnt + 1`, saturating at 255
  - the data update still occurs normally
- `clr_err=1`: `err <= 0`, `err_cnt <= 0`. If a new error occurs in the same cycle, the set wins: `err=1`, `err_cnt=1`.
- Reset (any time, mid-stream included): all synchronizer flops, `g_prev`, `bin_out`, `delta`, `bin_valid`, `err` and `err_cnt` go to 0. Gray 0 corresponds to binary 0, which matches the upstream counter's reset value.
- If `gray_in` is nonzero when reset is released, the first update reports `delta = g2b(value)`.

## Timing

- If `gray_in` changes and is stable before edge E1, `g_sync` shows the new value after edge E`SYNC_STAGES`. `bin_out`, `delta` and `bin_valid` update at edge E`SYNC_STAGES+1`.
- Latency is 3 edges with the default settings.
- `bin_valid` is high for exactly one cycle per distinct `g_sync` value. Back-to-back changes give back-to-back pulses.
- `err` and `err_cnt` update on the same edge as the corresponding `bin_valid`.
- `clr_err` takes effect on the next edge.
- All outputs are registered.

## Configuration

- `GRAY_SYNC_ERR_CHK_EN` defined:
  - the popcount checker, `err` register and `err_cnt` register are built
  - `clr_err` behaves as described above
- Not defined:
  - no checker logic is built
  - `err` and `err_cnt` are tied to 0
  - `clr_err` is ignored
  - data path and timing are identical to the defined case

## Test plan

- Reset, then hold `gray_in=0` for 10 cycles → `bin_out=0`, `delta=0`, `bin_valid=0`, `err=0`, `err_cnt=0` throughout.
- `gray_in` 0000→0001 → exactly 3 edges later, `bin_valid` pulses for one cycle with `bin_out=1`, `delta=1`. Then 0001→0011 → `bin_out=2`, `delta=1`.
- Step through the full Gray sequence to 1000 (binary 15), then to 0000 → final update has `bin_out=0`, `delta=1`, `bin_valid` pulse; 16 pulses total; `err=0`.
- With the macro on, 0000→0011 → `bin_out=2`, `delta=2`, `err=1`, `err_cnt=1`. Then pulse `clr_err` in the same cycle as a 0011→0101 jump → `err=1`, `err_cnt=1`.
- With the macro on, apply 300 multi-bit jumps → `err_cnt` saturates at 255. Then `clr_err` → `err=0`, `err_cnt=0`.
- Assert `rst_n` low mid-stream with `bin_out=9` → all outputs 0 immediately (asynchronous). Release with `gray_in=0110` → first pulse has `bin_out=4`, `delta=4`.
